// File: rtl/cdb_pkg.sv
// Shared CDB definitions.
// Holds the default ROB / physical-register geometry and the CDB packet
// layout. The ROB completion port and the ready-table update logic use the
// same packet layout.
package cdb_pkg;

    localparam int unsigned NUM_FU_DEF = 4;
    localparam int unsigned ROB_SIZE   = 16;
    localparam int unsigned ROB_IDX_W  = $clog2(ROB_SIZE);
    localparam int unsigned PREG_W     = 6;
    localparam int unsigned SRC_FU_W   = $clog2(NUM_FU_DEF);

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PREG_W-1:0]    dest_preg;
        logic [SRC_FU_W-1:0]  src_fu;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
// Scans req starting at ptr, wrapping at N (N need not be a power of two).
//   req : request vector
//   ptr : first index to consider (0..N-1)
//   gnt : one-hot grant, all-zero when no request
//   idx : encoded index of the granted request
//   any : at least one request present
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    int unsigned cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int unsigned k = 0; k < N; k++) begin
            // ptr < N, so one conditional subtract implements the wrap
            cand = 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter onto the common data bus.
// Accepts at most one FU completion per cycle (valid/ready) and registers it
// onto the CDB, which feeds the ROB completion port and the ready table.
//   clk, rst          : clock, asynchronous active-low reset
//   fu_valid/fu_ready : per-FU handshake, fu_ready is one-hot
//   fu_rob_idx        : per-FU ROB entry of the completion
//   fu_dest_preg      : per-FU destination physical register
//   cdb_stall         : consumer cannot take the CDB word this cycle
//   flush             : discard the CDB word, grant nothing this cycle
//   cdb_*             : registered CDB word and the FU that produced it
module cdb_arbiter #(
    parameter  int unsigned NUM_FU    = cdb_pkg::NUM_FU_DEF,
    parameter  int unsigned ROB_SIZE  = cdb_pkg::ROB_SIZE,
    parameter  int unsigned PREG_W    = cdb_pkg::PREG_W,
    localparam int unsigned ROB_IDX_W = $clog2(ROB_SIZE),
    localparam int unsigned SRC_W     = $clog2(NUM_FU)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_FU-1:0]                fu_valid,
    output logic [NUM_FU-1:0]                fu_ready,
    input  logic [NUM_FU-1:0][ROB_IDX_W-1:0] fu_rob_idx,
    input  logic [NUM_FU-1:0][PREG_W-1:0]    fu_dest_preg,
    input  logic                             cdb_stall,
    input  logic                             flush,
    output logic                             cdb_valid,
    output logic [ROB_IDX_W-1:0]             cdb_rob_idx,
    output logic [PREG_W-1:0]                cdb_dest_preg,
    output logic [SRC_W-1:0]                 cdb_src_fu
);

    logic [SRC_W-1:0]  rr_ptr;
    logic [NUM_FU-1:0] pick_gnt;
    logic [SRC_W-1:0]  pick;
    logic              pick_any;
    logic              can_load;

    rr_pick #(
        .N  (NUM_FU),
        .PW (SRC_W)
    ) u_pick (
        .req (fu_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick),
        .any (pick_any)
    );

    // Bus slot is free when empty or being drained this cycle; flush blocks it.
    assign can_load = ~flush & (~cdb_valid | ~cdb_stall);

    // rst gating keeps grants off while reset is held, independent of the
    // (already cleared) output register.
    assign fu_ready = (rst && can_load) ? pick_gnt : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid     <= 1'b0;
            cdb_rob_idx   <= '0;
            cdb_dest_preg <= '0;
            cdb_src_fu    <= '0;
            rr_ptr        <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (can_load) begin
            if (pick_any) begin
                cdb_valid     <= 1'b1;
                cdb_rob_idx   <= fu_rob_idx[pick];
                cdb_dest_preg <= fu_dest_preg[pick];
                cdb_src_fu    <= pick;
                rr_ptr        <= (pick == SRC_W'(NUM_FU - 1)) ? '0 : pick + 1'b1;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic             cdb_stall;
    logic             flush;

    // four-FU instance
    logic [3:0]       fu_valid;
    logic [3:0]       fu_ready;
    logic [3:0][3:0]  rob;
    logic [3:0][5:0]  preg;
    logic             cdb_valid;
    logic [3:0]       cdb_rob_idx;
    logic [5:0]       cdb_dest_preg;
    logic [1:0]       cdb_src_fu;

    // three-FU instance for the non-power-of-two wrap
    logic [2:0]       fu_valid3;
    logic [2:0]       fu_ready3;
    logic [2:0][3:0]  rob3;
    logic [2:0][5:0]  preg3;
    logic             cdb_valid3;
    logic [3:0]       cdb_rob_idx3;
    logic [5:0]       cdb_dest_preg3;
    logic [1:0]       cdb_src_fu3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_FU(4), .ROB_SIZE(16), .PREG_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .fu_valid      (fu_valid),
        .fu_ready      (fu_ready),
        .fu_rob_idx    (rob),
        .fu_dest_preg  (preg),
        .cdb_stall     (cdb_stall),
        .flush         (flush),
        .cdb_valid     (cdb_valid),
        .cdb_rob_idx   (cdb_rob_idx),
        .cdb_dest_preg (cdb_dest_preg),
        .cdb_src_fu    (cdb_src_fu)
    );

    cdb_arbiter #(.NUM_FU(3), .ROB_SIZE(16), .PREG_W(6)) dut3 (
        .clk           (clk),
        .rst           (rst),
        .fu_valid      (fu_valid3),
        .fu_ready      (fu_ready3),
        .fu_rob_idx    (rob3),
        .fu_dest_preg  (preg3),
        .cdb_stall     (cdb_stall),
        .flush         (flush),
        .cdb_valid     (cdb_valid3),
        .cdb_rob_idx   (cdb_rob_idx3),
        .cdb_dest_preg (cdb_dest_preg3),
        .cdb_src_fu    (cdb_src_fu3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp;
        rst       = 1'b0;
        cdb_stall = 1'b0;
        flush     = 1'b0;
        fu_valid  = 4'b1111;
        fu_valid3 = 3'b000;
        for (int i = 0; i < 4; i++) begin
            rob[i]  = 4'(i);
            preg[i] = 6'(i);
        end
        for (int i = 0; i < 3; i++) begin
            rob3[i]  = 4'(i + 12);
            preg3[i] = 6'(i + 40);
        end
        #1;
        // reset state, requests present but no grant while rst is low
        chk("rst_ready", 32'(fu_ready), 32'h0);
        chk("rst_valid", 32'(cdb_valid), 32'h0);
        chk("rst_idx",   32'(cdb_rob_idx), 32'h0);
        chk("rst_preg",  32'(cdb_dest_preg), 32'h0);
        chk("rst_src",   32'(cdb_src_fu), 32'h0);
        tick();
        tick();

        // single request from FU1
        rst      = 1'b1;
        fu_valid = 4'b0010;
        rob[1]   = 4'd5;
        preg[1]  = 6'd17;
        #1;
        chk("single_ready", 32'(fu_ready), 32'h2);
        tick();
        chk("single_valid", 32'(cdb_valid), 32'h1);
        chk("single_idx",   32'(cdb_rob_idx), 32'h5);
        chk("single_preg",  32'(cdb_dest_preg), 32'd17);
        chk("single_src",   32'(cdb_src_fu), 32'h1);
        // rr_ptr now 2: with FU1 and FU2 valid, FU2 must win
        fu_valid = 4'b0110;
        rob[2]   = 4'd7;
        preg[2]  = 6'd20;
        #1;
        chk("ptr2_ready", 32'(fu_ready), 32'h4);
        tick();
        chk("ptr2_src", 32'(cdb_src_fu), 32'h2);
        chk("ptr2_idx", 32'(cdb_rob_idx), 32'h7);
        fu_valid = 4'b0000;
        #1;
        chk("idle_ready", 32'(fu_ready), 32'h0);
        tick();
        chk("idle_valid", 32'(cdb_valid), 32'h0);

        // all valid, no stall: rr_ptr is 3, so order 3,0,1,2,3,0,1,2
        for (int i = 0; i < 4; i++) begin
            rob[i]  = 4'(i + 8);
            preg[i] = 6'(i + 32);
        end
        fu_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp = (3 + k) % 4;
            #1;
            chk("rr_ready", 32'(fu_ready), 32'(1 << exp));
            tick();
            chk("rr_valid", 32'(cdb_valid), 32'h1);
            chk("rr_src",   32'(cdb_src_fu), 32'(exp));
            chk("rr_idx",   32'(cdb_rob_idx), 32'(exp + 8));
            chk("rr_preg",  32'(cdb_dest_preg), 32'(exp + 32));
        end
        fu_valid = 4'b0000;
        tick();
        chk("rr_drain", 32'(cdb_valid), 32'h0);

        // stall: put idx 3 from FU0 on the bus (rr_ptr 3 -> 1)
        fu_valid = 4'b0001;
        rob[0]   = 4'd3;
        preg[0]  = 6'd9;
        tick();
        chk("stall_load", 32'(cdb_rob_idx), 32'h3);
        fu_valid  = 4'b0100;
        rob[2]    = 4'd11;
        preg[2]   = 6'd13;
        cdb_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready", 32'(fu_ready), 32'h0);
            tick();
            chk("stall_valid", 32'(cdb_valid), 32'h1);
            chk("stall_idx",   32'(cdb_rob_idx), 32'h3);
        end
        cdb_stall = 1'b0;
        #1;
        chk("unstall_ready", 32'(fu_ready), 32'h4);
        tick();
        chk("unstall_idx", 32'(cdb_rob_idx), 32'd11);
        chk("unstall_src", 32'(cdb_src_fu), 32'h2);

        // flush while stalled (rr_ptr 3): flush wins, FU3 granted afterwards
        cdb_stall = 1'b1;
        fu_valid  = 4'b1000;
        rob[3]    = 4'd14;
        flush     = 1'b1;
        #1;
        chk("flush_ready", 32'(fu_ready), 32'h0);
        tick();
        chk("flush_valid", 32'(cdb_valid), 32'h0);
        flush = 1'b0;
        #1;
        chk("postflush_ready", 32'(fu_ready), 32'h8);
        tick();
        chk("postflush_valid", 32'(cdb_valid), 32'h1);
        chk("postflush_src",   32'(cdb_src_fu), 32'h3);
        chk("postflush_idx",   32'(cdb_rob_idx), 32'd14);
        cdb_stall = 1'b0;

        // async reset mid-stream: rr_ptr 0 -> grant FU0 -> rr_ptr 1
        fu_valid = 4'b0001;
        rob[0]   = 4'd6;
        tick();
        chk("pre_rst_src", 32'(cdb_src_fu), 32'h0);
        fu_valid = 4'b1001;
        #1;
        chk("pre_rst_ready", 32'(fu_ready), 32'h8);
        #1;
        rst = 1'b0;
        #1;
        chk("async_valid", 32'(cdb_valid), 32'h0);
        chk("async_ready", 32'(fu_ready), 32'h0);
        chk("async_src",   32'(cdb_src_fu), 32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("rel_ready", 32'(fu_ready), 32'h1);
        tick();
        chk("rel_valid", 32'(cdb_valid), 32'h1);
        chk("rel_src",   32'(cdb_src_fu), 32'h0);
        chk("rel_idx",   32'(cdb_rob_idx), 32'h6);
        fu_valid = 4'b0000;

        // NUM_FU=3 wrap: FU1 grant puts rr_ptr at 2
        fu_valid3 = 3'b010;
        #1;
        chk("w3_first_ready", 32'(fu_ready3), 32'h2);
        tick();
        chk("w3_first_src", 32'(cdb_src_fu3), 32'h1);
        fu_valid3 = 3'b011;
        #1;
        chk("w3_wrap_ready", 32'(fu_ready3), 32'h1);
        tick();
        chk("w3_wrap_src", 32'(cdb_src_fu3), 32'h0);
        chk("w3_wrap_idx", 32'(cdb_rob_idx3), 32'd12);
        fu_valid3 = 3'b010;
        #1;
        chk("w3_fu1_ready", 32'(fu_ready3), 32'h2);
        tick();
        chk("w3_fu1_src", 32'(cdb_src_fu3), 32'h1);
        chk("w3_fu1_preg", 32'(cdb_dest_preg3), 32'd41);
        // rr_ptr back at 2: FU2 wins among all three
        fu_valid3 = 3'b111;
        #1;
        chk("w3_ptr2_ready", 32'(fu_ready3), 32'h4);
        tick();
        chk("w3_ptr2_src", 32'(cdb_src_fu3), 32'h2);
        fu_valid3 = 3'b000;
        tick();
        chk("w3_drain", 32'(cdb_valid3), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
